// File: rtl/ssd_search_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_search_ctrl_pkg
//  Purpose  : Shared types and constants for the SSD block-search controller.
//  Revision : 1.0 - initial release
// ============================================================================
package ssd_search_ctrl_pkg;

  // Default block geometry and candidate count.
  localparam int BLK_W_DEF = 8;
  localparam int BLK_H_DEF = 8;
  localparam int NCAND_DEF = 16;

  // Pixel and squared-difference widths.
  localparam int PIX_W = 8;
  localparam int SQR_W = 2 * PIX_W;

  // Widths derived from the defaults.
  localparam int BLK_N_DEF = BLK_W_DEF * BLK_H_DEF;
  localparam int ACC_W_DEF = SQR_W + $clog2(BLK_N_DEF);
  localparam int IDX_W_DEF = $clog2(NCAND_DEF);

  // The squaring unit takes two cycles, so after the last accept the
  // controller must wait this long before the sum is complete.
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_W      = 2;

  // Controller state encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ssd_search_ctrl_sqr_abs_sub.sv
`default_nettype none
// ============================================================================
//  Module   : sqr_abs_sub
//  Purpose  : Two-stage pipelined squared absolute difference |a-b|^2.
//             Stage 1 registers |a-b| when enabled, stage 2 squares it.
//  Revision : 1.0 - initial release
// ============================================================================
module sqr_abs_sub
  import ssd_search_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [SQR_W-1:0] z_o
);

  logic [PIX_W-1:0] diff_q;
  logic [SQR_W-1:0] sq_q;

  // Stage 1: capture the absolute difference of an accepted pair.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      diff_q <= '0;
    end else if (en_i) begin
      diff_q <= (a_i > b_i) ? (a_i - b_i) : (b_i - a_i);
    end
  end

  // Stage 2: square it; free-running because validity is tracked upstream.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_q <= '0;
    end else begin
      sq_q <= {{PIX_W{1'b0}}, diff_q} * {{PIX_W{1'b0}}, diff_q};
    end
  end

  assign z_o = sq_q;

endmodule
`default_nettype wire

// File: rtl/ssd_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_search_ctrl
//  Purpose  : Runs one shared squared-difference unit over BLK_N pixel pairs
//             per candidate, for NCAND candidates, and reports the candidate
//             with the smallest sum of squared differences.
//  Revision : 1.0 - initial release
// ============================================================================
module ssd_search_ctrl
  import ssd_search_ctrl_pkg::*;
#(
  parameter  int BLK_W = BLK_W_DEF,
  parameter  int BLK_H = BLK_H_DEF,
  parameter  int NCAND = NCAND_DEF,
  localparam int BLK_N = BLK_W * BLK_H,
  localparam int IDX_W = $clog2(NCAND),
  localparam int ACC_W = SQR_W + $clog2(BLK_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [PIX_W-1:0] pix_a_i,
  input  logic [PIX_W-1:0] pix_b_i,
  output logic             busy_o,
  output logic             cand_valid_o,
  output logic [ACC_W-1:0] cand_ssd_o,
  output logic             done_o,
  output logic [IDX_W-1:0] best_idx_o,
  output logic [ACC_W-1:0] best_ssd_o
);

  localparam int CNT_W = $clog2(BLK_N);
  localparam logic [CNT_W-1:0]   PIX_LAST   = CNT_W'(BLK_N - 1);
  localparam logic [IDX_W-1:0]   CAND_LAST  = IDX_W'(NCAND - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic [IDX_W-1:0]   cand_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   min_q;
  logic [IDX_W-1:0]   min_idx_q;
  logic [ACC_W-1:0]   cand_ssd_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [ACC_W-1:0]   best_ssd_q;
  logic               v1_q, v2_q;

  logic               acc_en;
  logic [SQR_W-1:0]   sq;
  logic               last_cand;
  logic               acc_lt_min;
  logic [ACC_W-1:0]   min_upd;
  logic [IDX_W-1:0]   min_idx_upd;

  assign acc_en      = pix_valid_i & pix_ready_o;
  assign last_cand   = (cand_q == CAND_LAST);
  assign acc_lt_min  = (acc_q < min_q);
  assign min_upd     = acc_lt_min ? acc_q : min_q;
  assign min_idx_upd = acc_lt_min ? cand_q : min_idx_q;

  sqr_abs_sub u_sqr (
    .clk    (clk),
    .rst_ni (~rst),
    .en_i   (acc_en),
    .a_i    (pix_a_i),
    .b_i    (pix_b_i),
    .z_o    (sq)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (acc_en && (pix_cnt_q == PIX_LAST)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DRAIN_LAST) state_d = ST_CMP;
      ST_CMP:   state_d = last_cand ? ST_DONE : ST_RUN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; cand_ssd shows the live sum during CMP, then holds.
  always_comb begin
    pix_ready_o  = (state_q == ST_RUN);
    busy_o       = (state_q != ST_IDLE);
    cand_valid_o = (state_q == ST_CMP);
    done_o       = (state_q == ST_DONE);
    cand_ssd_o   = (state_q == ST_CMP) ? acc_q : cand_ssd_q;
  end

  // Counters, compare/minimum tracking and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_q  <= '0;
      cand_q     <= '0;
      drain_q    <= '0;
      min_q      <= '0;
      min_idx_q  <= '0;
      cand_ssd_q <= '0;
      best_idx_q <= '0;
      best_ssd_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cand_q    <= '0;
            pix_cnt_q <= '0;
            min_q     <= '1;
            min_idx_q <= '0;
          end
        end
        ST_RUN: begin
          drain_q <= '0;
          if (acc_en) begin
            pix_cnt_q <= (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_q <= drain_q + 1'b1;
        end
        ST_CMP: begin
          cand_ssd_q <= acc_q;
          min_q      <= min_upd;
          min_idx_q  <= min_idx_upd;
          // Result is loaded here so it is already stable while done is high.
          if (last_cand) begin
            best_ssd_q <= min_upd;
            best_idx_q <= min_idx_upd;
          end else begin
            cand_q <= cand_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Validity pipe matching the squaring latency, and the SSD accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      v1_q <= acc_en;
      v2_q <= v1_q;
      if ((state_q == ST_CMP) || ((state_q == ST_IDLE) && start_i)) begin
        acc_q <= '0;
      end else if (v2_q) begin
        acc_q <= acc_q + ACC_W'(sq);
      end
    end
  end

  assign best_idx_o = best_idx_q;
  assign best_ssd_o = best_ssd_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_search_ctrl
//  Purpose  : Randomised scoreboard bench for ssd_search_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_search_ctrl;

  localparam int NC  = 16;
  localparam int BN  = 64;
  localparam int TOT = NC * BN;
  localparam int AW  = 22;
  localparam int IW  = 4;
  localparam int LAT = 1 + NC * (BN + 3);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_a, pix_b;
  logic          busy, cand_valid, done;
  logic [AW-1:0] cand_ssd, best_ssd;
  logic [IW-1:0] best_idx;

  ssd_search_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .pix_valid_i  (pix_valid),
    .pix_ready_o  (pix_ready),
    .pix_a_i      (pix_a),
    .pix_b_i      (pix_b),
    .busy_o       (busy),
    .cand_valid_o (cand_valid),
    .cand_ssd_o   (cand_ssd),
    .done_o       (done),
    .best_idx_o   (best_idx),
    .best_ssd_o   (best_ssd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model -----------------
  int A [TOT];
  int B [TOT];
  int ssd [NC];
  int exp_bi, exp_bs;

  task automatic gen(input int mode);
    for (int k = 0; k < NC; k++) begin
      for (int i = 0; i < BN; i++) begin
        int j;
        j = k * BN + i;
        case (mode)
          0: begin A[j] = 77; B[j] = 77; end
          1: begin A[j] = 10; B[j] = 10 + (15 - k); end
          2: begin
            if (k == 0)      begin A[j] = 255; B[j] = 0;   end
            else if (k == 1) begin A[j] = 0;   B[j] = 255; end
            else begin A[j] = $urandom_range(255, 0); B[j] = $urandom_range(255, 0); end
          end
          3: begin
            if (k == 3 || k == 7) begin
              if (i == 0) begin A[j] = (k == 3) ? 100 : 108; B[j] = (k == 3) ? 108 : 100; end
              else begin A[j] = 50; B[j] = 50; end
            end else begin
              A[j] = 0; B[j] = $urandom_range(255, 20);
            end
          end
          default: begin A[j] = $urandom_range(255, 0); B[j] = $urandom_range(255, 0); end
        endcase
      end
    end
    for (int k = 0; k < NC; k++) begin
      ssd[k] = 0;
      for (int i = 0; i < BN; i++) begin
        int d;
        d = A[k * BN + i] - B[k * BN + i];
        ssd[k] += d * d;
      end
    end
    exp_bi = 0;
    exp_bs = ssd[0];
    for (int k = 1; k < NC; k++) begin
      if (ssd[k] < exp_bs) begin exp_bs = ssd[k]; exp_bi = k; end
    end
  endtask

  // ---------------- scoreboard -----------------
  int exp_cand_q [$];
  int exp_idx_q  [$];
  int exp_best_q [$];

  // ---------------- monitor -----------------
  int  acc_cnt    = 0;
  int  pend       = 0;
  int  cand_seen  = 0;
  bit  done_next  = 1'b0;
  int  done_count = 0;
  int  done_cyc   = 0;

  always @(negedge clk) begin
    if (rst) begin
      acc_cnt   = 0;
      pend      = 0;
      cand_seen = 0;
      done_next = 1'b0;
    end else begin
      bit exp_cv, exp_dn;
      exp_cv = (pend == 1);
      exp_dn = done_next;
      done_next = 1'b0;
      if (pend > 0) begin
        chk("drain_ready", pix_ready, 0);
        pend--;
      end
      chk("cand_valid_timing", cand_valid, exp_cv);
      chk("done_timing", done, exp_dn);
      if (!busy) chk("idle_ready", pix_ready, 0);
      if (cand_valid) begin
        if (exp_cand_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL cand_ssd: got %0d with no expected entry", cand_ssd);
        end else begin
          chk("cand_ssd", cand_ssd, exp_cand_q.pop_front());
        end
        cand_seen++;
        if (cand_seen == NC) begin cand_seen = 0; done_next = 1'b1; end
      end
      if (done) begin
        chk("done_ready", pix_ready, 0);
        chk("done_busy", busy, 1);
        if (exp_idx_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL best: got idx %0d ssd %0d with no expected entry", best_idx, best_ssd);
        end else begin
          chk("best_idx", best_idx, exp_idx_q.pop_front());
          chk("best_ssd", best_ssd, exp_best_q.pop_front());
        end
        done_cyc = cyc;
        done_count++;
      end
      if (pix_valid && pix_ready) begin
        acc_cnt++;
        if (acc_cnt % BN == 0) pend = 3;
      end
    end
  end

  // ---------------- driver -----------------
  task automatic run_search(input int mode, input int gap, input bit chk_lat,
                            input int abort_at, input bit glitch);
    int idx, n, start_cyc, dc0;
    bit tog, v, acc, glitched;
    gen(mode);
    if (abort_at < 0) begin
      for (int k = 0; k < NC; k++) exp_cand_q.push_back(ssd[k]);
      exp_idx_q.push_back(exp_bi);
      exp_best_q.push_back(exp_bs);
    end else begin
      for (int k = 0; k < abort_at / BN; k++) exp_cand_q.push_back(ssd[k]);
    end
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    idx = 0; n = 0; tog = 1'b1; glitched = 1'b0;
    while (idx < TOT && n < 8000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      case (gap)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(2, 0) != 0);
      endcase
      tog = ~tog;
      pix_valid = v;
      pix_a = 8'(A[idx]);
      pix_b = 8'(B[idx]);
      if (glitch && !glitched && idx == 100) begin start = 1'b1; glitched = 1'b1; end
      else start = 1'b0;
      acc = v && pix_ready;
      @(negedge clk);
      n++;
      if (acc) idx++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    if (n >= 8000) begin
      vectors++; miscompares++;
      $display("FAIL feed_timeout: accepted %0d of %0d pairs", idx, TOT);
    end
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_ready", pix_ready, 0);
      chk("rst_best_idx", best_idx, 0);
      chk("rst_best_ssd", best_ssd, 0);
      chk("rst_cand_ssd", cand_ssd, 0);
      chk("rst_pending", exp_cand_q.size(), 0);
      exp_cand_q.delete();
      @(negedge clk);
      chk("rst_idle_busy", busy, 0);
    end else begin
      n = 0;
      while (done_count == dc0 && n < 100) begin @(negedge clk); n++; end
      chk("done_seen", done_count - dc0, 1);
      if (chk_lat) chk("done_latency", done_cyc - start_cyc, LAT);
      repeat (3) @(negedge clk);
      chk("held_best_idx", best_idx, exp_bi);
      chk("held_best_ssd", best_ssd, exp_bs);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_a = '0; pix_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ready", pix_ready, 0);
    chk("reset_cand_valid", cand_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_best_idx", best_idx, 0);
    chk("reset_best_ssd", best_ssd, 0);
    chk("reset_cand_ssd", cand_ssd, 0);
    rst = 1'b0;
    @(negedge clk);

    run_search(0, 0, 1'b1, -1, 1'b0);       // identical pixels
    run_search(1, 0, 1'b1, -1, 1'b0);       // graded offsets, best is 15
    run_search(2, 0, 1'b1, -1, 1'b0);       // full-scale differences
    run_search(3, 0, 1'b0, -1, 1'b0);       // tie between 3 and 7
    run_search(1, 1, 1'b0, -1, 1'b0);       // alternating valid
    run_search(4, 2, 1'b0, -1, 1'b0);       // random data, random gaps
    run_search(4, 0, 1'b0, 5 * BN + 10, 1'b0); // reset inside candidate 5
    run_search(4, 0, 1'b1, -1, 1'b1);       // clean run, stray start mid-RUN
    run_search(4, 1, 1'b0, -1, 1'b0);

    repeat (5) @(negedge clk);
    chk("end_queue_empty", exp_cand_q.size() + exp_idx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
